l2c_cout_sched: RTL and testbench

- N-channel scheduler for the L2 cache core-out return path; generalises the 2-channel combinational mux to N requesters (cbus, xu, future DMA/snoop sources).
- Round-robin arbitration with burst lock: a multi-beat transfer is never interleaved with another channel.
- A registered output stage drives the core-out bus and honours downstream stall.

---
 rtl/l2c_cout_sched_pkg.sv | 27 ++
 rtl/l2c_cout_sched_if.sv | 39 +++
 rtl/l2c_cout_sched_arb.sv | 43 ++++
 rtl/l2c_cout_sched.sv | 119 +++++++++++
 tb/tb_l2c_cout_sched.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/l2c_cout_sched_pkg.sv
// l2c_cout_sched_pkg
//   Shared constants, types and helpers for the L2 cache core-out scheduler.
//   Channel index constants name the fixed requesters; the width constants
//   stand in for the core-wide uid/data widths.
package l2c_cout_sched_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam int CORE_UID_W    = 8;
    localparam int CORE_DATA_W   = 32;

    localparam int L2C_SCHED_NCH = 4;
    localparam int L2C_CH_CBUS   = 0;
    localparam int L2C_CH_XU     = 1;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } sched_state_e;

    // Channel after idx, wrapping at nch so indices >= nch never appear.
    function automatic int next_ch(input int idx, input int nch);
        return (idx + 1 >= nch) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/l2c_cout_sched_if.sv
// l2c_cout_sched_if
//   Requester-side and core-out-side signals of the scheduler.
//   master : requesters + downstream (drives req*, stall; sees ack, beat out)
//   slave  : the scheduler itself
//   req/req_uid/req_data/req_last : per-channel beat offer (flattened, channel
//                                   i at [i*W +: W])
//   ack                           : one-hot beat accepted (combinational)
//   grnt_idx/locked               : current/last owner, burst in progress
//   stall                         : downstream back-pressure
//   rdy/uid/data/last             : registered output beat
interface l2c_cout_sched_if #(
    parameter int NCH    = 4,
    parameter int UID_W  = 8,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 3
);
    logic [NCH-1:0]        req;
    logic [NCH*UID_W-1:0]  req_uid;
    logic [NCH*DATA_W-1:0] req_data;
    logic [NCH-1:0]        req_last;
    logic [NCH-1:0]        ack;
    logic [IDX_W-1:0]      grnt_idx;
    logic                  locked;
    logic                  stall;
    logic                  rdy;
    logic [UID_W-1:0]      uid;
    logic [DATA_W-1:0]     data;
    logic                  last;

    modport master (
        output req, req_uid, req_data, req_last, stall,
        input  ack, grnt_idx, locked, rdy, uid, data, last
    );

    modport slave (
        input  req, req_uid, req_data, req_last, stall,
        output ack, grnt_idx, locked, rdy, uid, data, last
    );
endinterface

// File: rtl/l2c_cout_sched_arb.sv
// arb_nch_rr_lock
//   Combinational round-robin winner search with burst lock.
//   req    : per-channel requests
//   ptr    : highest-priority channel when unlocked
//   locked : burst in progress; only owner may win
//   owner  : channel holding the burst
//   grant  : one-hot winner, zero when nobody eligible requests
module arb_nch_rr_lock #(
    parameter int NCH   = 4,
    parameter int IDX_W = 3
) (
    input  logic [NCH-1:0]   req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             locked,
    input  logic [IDX_W-1:0] owner,
    output logic [NCH-1:0]   grant
);

    logic found;

    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        grant = '0;
        found = 1'b0;
        if (locked) begin
            for (int i = 0; i < NCH; i++) begin
                if (owner == IDX_W'(i)) grant[i] = req[i];
            end
        end else begin
            // Visit ptr, ptr+1, ... modulo NCH; the first requester wins.
            for (int k = 0; k < NCH; k++) begin
                for (int i = 0; i < NCH; i++) begin
                    if (!found && req[i] && ((int'(ptr) + k) % NCH == i)) begin
                        grant[i] = 1'b1;
                        found    = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/l2c_cout_sched.sv
// l2c_cout_sched
//   N-channel scheduler for the L2 core-out return path. Round-robin between
//   requesters, a multi-beat transfer keeps the bus until its last beat, and
//   a registered output stage honours downstream stall.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : l2c_cout_sched_if slave (requests in, ack/status/beat out)
module l2c_cout_sched
    import l2c_cout_sched_pkg::*;
#(
    parameter int NCH    = L2C_SCHED_NCH,
    parameter int UID_W  = CORE_UID_W,
    parameter int DATA_W = CORE_DATA_W,
    parameter int IDX_W  = 3
) (
    input  logic                clk,
    input  logic                rst,
    l2c_cout_sched_if.slave     bus
);

    sched_state_e      state, state_nxt;
    logic [IDX_W-1:0]  ptr, ptr_nxt;
    logic [IDX_W-1:0]  grnt_q, grnt_nxt;
    logic [NCH-1:0]    grant;
    logic [IDX_W-1:0]  win_idx;
    logic [UID_W-1:0]  win_uid;
    logic [DATA_W-1:0] win_data;
    logic              win_last;
    logic              take, fire;
    logic              rdy_q, last_q;
    logic [UID_W-1:0]  uid_q;
    logic [DATA_W-1:0] data_q;

    arb_nch_rr_lock #(.NCH(NCH), .IDX_W(IDX_W)) u_arb (
        .req    (bus.req),
        .ptr    (ptr),
        .locked (state == ST_LOCKED),
        .owner  (grnt_q),
        .grant  (grant)
    );

    // A beat can enter the output stage if it is empty or draining now.
    // Reset forces ack low even though the arbiter still sees requests.
    assign take    = !rdy_q || !bus.stall;
    assign fire    = take && !rst && (|grant);
    assign bus.ack = fire ? grant : '0;

    // Mux the winning channel's beat with constant indices.
    always_comb begin
        win_idx  = '0;
        win_uid  = '0;
        win_data = '0;
        win_last = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                win_idx  = IDX_W'(i);
                win_uid  = bus.req_uid[i*UID_W +: UID_W];
                win_data = bus.req_data[i*DATA_W +: DATA_W];
                win_last = bus.req_last[i];
            end
        end
    end

    // Next state. In LOCKED the arbiter only grants the owner, so win_idx
    // equals grnt_q and the same update covers both states.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        grnt_nxt  = grnt_q;
        if (fire) begin
            grnt_nxt = win_idx;
            if (win_last) begin
                state_nxt = ST_UNLOCKED;
                ptr_nxt   = IDX_W'(next_ch(int'(win_idx), NCH));
            end else begin
                state_nxt = ST_LOCKED;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_UNLOCKED;
            ptr    <= '0;
            grnt_q <= '0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            grnt_q <= grnt_nxt;
        end
    end

    // Output stage: load on fire, drop rdy when the beat drains with nothing
    // behind it, otherwise hold (covers rdy && stall).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q  <= DISABLE;
            uid_q  <= '0;
            data_q <= '0;
            last_q <= 1'b0;
        end else if (fire) begin
            rdy_q  <= ENABLE;
            uid_q  <= win_uid;
            data_q <= win_data;
            last_q <= win_last;
        end else if (!bus.stall) begin
            rdy_q  <= DISABLE;
        end
    end

    assign bus.rdy      = rdy_q;
    assign bus.uid      = uid_q;
    assign bus.data     = data_q;
    assign bus.last     = last_q;
    assign bus.grnt_idx = grnt_q;
    assign bus.locked   = (state == ST_LOCKED);

endmodule

// File: tb/tb_l2c_cout_sched.sv
// tb_l2c_cout_sched
//   Directed bench for l2c_cout_sched: a 4-channel instance for most cases and
//   a 3-channel instance for the non-power-of-2 wrap.
module tb_l2c_cout_sched;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    l2c_cout_sched_if #(.NCH(4), .UID_W(8), .DATA_W(32), .IDX_W(3)) sif ();
    l2c_cout_sched_if #(.NCH(3), .UID_W(8), .DATA_W(32), .IDX_W(3)) sif3 ();

    l2c_cout_sched #(.NCH(4), .UID_W(8), .DATA_W(32), .IDX_W(3)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    l2c_cout_sched #(.NCH(3), .UID_W(8), .DATA_W(32), .IDX_W(3)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (sif3.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Leaves time at posedge+1, safely away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sif.req   = '0;
        sif.stall = 1'b0;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [3:0] t1_ack  [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    logic [2:0] t1_grnt [4] = '{3'd0, 3'd2, 3'd0, 3'd2};

    initial begin
        sif.req      = '0;
        sif.req_last = '1;
        sif.req_uid  = {8'h13, 8'h12, 8'h11, 8'h10};
        sif.req_data = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        sif.stall    = 1'b0;
        sif3.req      = '0;
        sif3.req_last = '1;
        sif3.req_uid  = {8'h22, 8'h21, 8'h20};
        sif3.req_data = '0;
        sif3.stall    = 1'b0;

        // Reset state
        do_reset();
        check("rst_rdy",    sif.rdy, 0);
        check("rst_uid",    sif.uid, 0);
        check("rst_data",   sif.data, 0);
        check("rst_locked", sif.locked, 0);
        check("rst_grnt",   sif.grnt_idx, 0);
        check("rst_ack",    sif.ack, 0);

        // Two single-beat requesters alternate
        sif.req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("alt_ack", sif.ack, t1_ack[k]);
            tick();
            check("alt_grnt", sif.grnt_idx, t1_grnt[k]);
            check("alt_rdy",  sif.rdy, 1);
            check("alt_uid",  sif.uid, 8'h10 + t1_grnt[k]);
        end

        // ch1 4-beat burst, ch3 waiting
        do_reset();
        sif.req      = 4'b1010;
        sif.req_last = 4'b1000;
        for (int b = 0; b < 4; b++) begin
            sif.req_data[63:32] = 32'hB000_0000 + b;
            sif.req_last[1]     = (b == 3);
            #1;
            check("burst_ack", sif.ack, 4'b0010);
            tick();
            check("burst_locked", sif.locked, (b < 3) ? 1 : 0);
            check("burst_data",   sif.data, 32'hB000_0000 + b);
            check("burst_last",   sif.last, (b == 3) ? 1 : 0);
        end
        sif.req[1] = 1'b0;
        #1;
        check("after_burst_ack", sif.ack, 4'b1000);
        tick();
        check("after_burst_grnt", sif.grnt_idx, 3);

        // Stall holds the output beat and blocks new acks
        do_reset();
        sif.req_last        = 4'b1111;
        sif.req_uid[23:16]  = 8'h5A;
        sif.req_data[95:64] = 32'hDEAD_BEEF;
        sif.req             = 4'b0100;
        #1;
        check("stall_first_ack", sif.ack, 4'b0100);
        tick();
        check("stall_first_rdy", sif.rdy, 1);
        sif.req   = 4'b0001;
        sif.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_ack", sif.ack, 0);
            tick();
            check("stall_rdy",  sif.rdy, 1);
            check("stall_uid",  sif.uid, 8'h5A);
            check("stall_data", sif.data, 32'hDEAD_BEEF);
        end
        sif.stall = 1'b0;
        #1;
        check("unstall_ack", sif.ack, 4'b0001);
        tick();
        check("unstall_uid", sif.uid, 8'h10);
        sif.req = '0;

        // Three channels: wrap from 2 back to 0
        sif3.req = 3'b111;
        for (int k = 0; k < 7; k++) begin
            #1;
            check("n3_ack", sif3.ack, 3'b001 << (k % 3));
            tick();
            check("n3_grnt", sif3.grnt_idx, k % 3);
        end
        sif3.req = '0;

        // Owner drops req mid-burst: lock held, others starved
        do_reset();
        sif.req_last = 4'b0000;
        sif.req      = 4'b0001;
        #1;
        check("drop_first_ack", sif.ack, 4'b0001);
        tick();
        check("drop_first_locked", sif.locked, 1);
        sif.req      = 4'b0010;
        sif.req_last = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("drop_ack", sif.ack, 0);
            tick();
            check("drop_locked", sif.locked, 1);
            check("drop_rdy",    sif.rdy, 0);
        end
        sif.req      = 4'b0011;
        sif.req_last = 4'b0011;
        #1;
        check("resume_ack", sif.ack, 4'b0001);
        tick();
        check("resume_locked", sif.locked, 0);
        sif.req[0] = 1'b0;
        #1;
        check("resume_next_ack", sif.ack, 4'b0010);
        tick();

        // Reset mid-burst with a beat in the output stage
        do_reset();
        sif.req_last = 4'b0000;
        sif.req      = 4'b0001;
        tick();
        check("mid_locked", sif.locked, 1);
        check("mid_rdy",    sif.rdy, 1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_rdy",    sif.rdy, 0);
        check("mid_rst_locked", sif.locked, 0);
        check("mid_rst_ack",    sif.ack, 0);
        sif.req      = 4'b1000;
        sif.req_last = 4'b1000;
        rst = 1'b0;
        #1;
        check("post_rst_ack", sif.ack, 4'b1000);
        tick();
        check("post_rst_grnt", sif.grnt_idx, 3);
        check("post_rst_rdy",  sif.rdy, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
